pwm_cmd_ctrl: RTL and testbench
===============================

PWM_CMD_CTRL -- requirements
Module: pwm_cmd_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of PWM channels controlled (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 270000: maximum idle clk cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk  in  1: single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data  in  8: received UART byte.
REQ-006 SHALL have port rx_valid  in  1: rx_data is valid; the byte is consumed on an edge where rx_valid=1 and rx_ready=1.
REQ-007 SHALL have port rx_ready  out  1: controller can accept a byte.
REQ-008 SHALL have port duty_o  out  8*N_CH: per-channel duty; channel c occupies bits [8c+7:8c].
REQ-009 SHALL have port en_o  out  N_CH: per-channel PWM enable.
REQ-010 SHALL have port uart_rx_bytes  out  24: last accepted frame, {byte0,byte1,byte2}, kept as a debug probe.
REQ-011 SHALL have port frame_ok  out  1: one-cycle pulse when a frame is applied.
REQ-012 SHALL have port frame_err  out  1: one-cycle pulse when a frame is rejected.
REQ-013 SHALL have port err_cnt  out  8: saturating count of rejected frames.

Function
REQ-014 SHALL use a fixed 3-byte frame. byte0: [7:4]=4'hA sync, [3:2]=opcode, [1:0]=channel. byte1: value. byte2: checksum = byte0 ^ byte1.
REQ-015 SHALL use FSM states IDLE, B1, B2, APPLY.
REQ-016 In IDLE, a consumed byte with [7:4]=4'hA SHALL be stored as byte0 and move the FSM to B1. Any other byte SHALL be discarded silently, with no frame_err (resync).
REQ-017 In B1, a consumed byte SHALL be stored as byte1 and move the FSM to B2.
REQ-018 In B2, a consumed byte SHALL be stored as byte2 and move the FSM to APPLY.
REQ-019 rx_ready SHALL be 1 in IDLE, B1 and B2, and 0 in APPLY; APPLY SHALL last exactly one cycle and then return to IDLE.
REQ-020 On the APPLY edge, a frame with a valid checksum SHALL be decoded as follows.
- opcode 00: duty_o[channel] <= byte1.
- opcode 01: en_o[channel] <= byte1[0].
- opcode 10: duty_o of all channels <= byte1.
- In every case: uart_rx_bytes <= frame, frame_ok=1 for one cycle.
REQ-021 On the APPLY edge, a frame SHALL be rejected if any of these holds: checksum mismatch, opcode 11, or channel >= N_CH.
- On rejection: frame_err=1 for one cycle, err_cnt increments, and duty_o, en_o and uart_rx_bytes are unchanged.
REQ-022 Latency: byte2 is consumed on edge k; duty_o, en_o and frame_ok SHALL reflect the frame after edge k+1.
REQ-023 A timeout counter SHALL clear on every consumed byte and increment on every cycle in B1 or B2 with no consumed byte. When it reaches TIMEOUT_CYC-1, the FSM SHALL go to IDLE, drop the partial frame, pulse frame_err and increment err_cnt.
REQ-024 If rx_valid=1 on the same edge the timeout would fire, the byte SHALL win and the timeout SHALL NOT fire.
REQ-025 err_cnt SHALL saturate at 255 and SHALL NOT wrap to 0.
REQ-026 frame_ok and frame_err SHALL never be 1 in the same cycle.

Reset
REQ-027 On rst=1 the block SHALL asynchronously set: FSM=IDLE, duty_o=0, en_o=0, uart_rx_bytes=0, frame_ok=0, frame_err=0, err_cnt=0, timeout counter=0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame, with no frame_err pulse after release.
REQ-029 rx_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Valid set-duty: bytes A1,80,21 -> duty_o[ch1]=0x80, frame_ok pulses at k+1, uart_rx_bytes=0xA18021.
REQ-031 Bad checksum: bytes A0,55,00 -> frame_err pulses, err_cnt=1, duty_o unchanged.
REQ-032 Resync: bytes 3C,A4,01,A5 -> 3C dropped, en_o[ch0]=1, no frame_err.
REQ-033 Timeout, with TIMEOUT_CYC=16: byte A0 then 16 idle cycles -> frame_err pulses, FSM=IDLE; a following frame A0,10,B0 is applied.
REQ-034 Saturation: 300 bad frames -> err_cnt=255.
REQ-035 Reset after A0,10 -> all outputs 0, no frame_err; a fresh full frame is then accepted.

Source files
------------

// File: rtl/pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmd_ctrl
// Brief    : 3-byte UART command decoder driving per-channel PWM duty/enable.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_cmd_ctrl #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 270000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [8*N_CH-1:0]   duty_o,
  output logic [N_CH-1:0]     en_o,
  output logic [23:0]         uart_rx_bytes,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [7:0]          err_cnt
);

  localparam int                C_TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]        C_NCH     = 3'(N_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_B1    = 2'd1,
    ST_B2    = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_b0;
  logic [7:0]          r_b1;
  logic [7:0]          r_b2;
  logic [C_TO_W-1:0]   r_to_cnt;
  logic [8*N_CH-1:0]   r_duty;
  logic [N_CH-1:0]     r_en;
  logic [23:0]         r_bytes;
  logic                r_ok;
  logic                r_err;
  logic [7:0]          r_err_cnt;

  logic                w_take;
  logic                w_timeout;
  logic                w_bad;
  logic                w_good;
  logic                w_reject;
  logic [1:0]          w_opc;
  logic [1:0]          w_ch;

  assign rx_ready      = (r_state != ST_APPLY);
  assign w_take        = rx_valid & rx_ready;
  assign w_opc         = r_b0[3:2];
  assign w_ch          = r_b0[1:0];
  assign w_bad         = ((r_b0 ^ r_b1) != r_b2) || (w_opc == 2'b11) || ({1'b0, w_ch} >= C_NCH);
  assign w_good        = (r_state == ST_APPLY) && !w_bad;
  assign w_reject      = ((r_state == ST_APPLY) && w_bad) || w_timeout;

  assign duty_o        = r_duty;
  assign en_o          = r_en;
  assign uart_rx_bytes = r_bytes;
  assign frame_ok      = r_ok;
  assign frame_err     = r_err;
  assign err_cnt       = r_err_cnt;

  // A byte arriving on the expiry edge takes priority over the timeout.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_take && rx_data[7:4] == 4'hA) w_next = ST_B1;
      ST_B1: begin
        if (w_take) w_next = ST_B2;
        else if (r_to_cnt == C_TO_LAST) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_B2: begin
        if (w_take) w_next = ST_APPLY;
        else if (r_to_cnt == C_TO_LAST) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_APPLY: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b0      <= 8'h00;
      r_b1      <= 8'h00;
      r_b2      <= 8'h00;
      r_to_cnt  <= '0;
      r_duty    <= '0;
      r_en      <= '0;
      r_bytes   <= 24'h0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_ok  <= w_good;
      r_err <= w_reject;
      if (w_reject && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_take || w_timeout || !(r_state == ST_B1 || r_state == ST_B2))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_take) begin
        case (r_state)
          ST_IDLE: r_b0 <= rx_data;
          ST_B1:   r_b1 <= rx_data;
          ST_B2:   r_b2 <= rx_data;
          default: ;
        endcase
      end

      if (w_good) begin
        r_bytes <= {r_b0, r_b1, r_b2};
        for (int c = 0; c < N_CH; c++) begin
          if (w_opc == 2'b10 || (w_opc == 2'b00 && w_ch == 2'(c)))
            r_duty[8*c +: 8] <= r_b1;
          if (w_opc == 2'b01 && w_ch == 2'(c))
            r_en[c] <= r_b1[0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cmd_ctrl
// Brief    : Directed plus randomized bench for pwm_cmd_ctrl with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_cmd_ctrl;

  localparam int N_CH = 3;
  localparam int TO   = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic                rx_ready;
  logic [8*N_CH-1:0]   duty_o;
  logic [N_CH-1:0]     en_o;
  logic [23:0]         uart_rx_bytes;
  logic                frame_ok;
  logic                frame_err;
  logic [7:0]          err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  m_duty [N_CH];
  logic        m_en   [N_CH];
  logic [23:0] m_bytes;
  int          m_err;

  pwm_cmd_ctrl #(.N_CH(N_CH), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .duty_o       (duty_o),
    .en_o         (en_o),
    .uart_rx_bytes(uart_rx_bytes),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_duty[c] = 8'h00;
      m_en[c]   = 1'b0;
    end
    m_bytes = 24'h0;
    m_err   = 0;
  endtask

  task automatic model_reject();
    if (m_err < 255) m_err++;
  endtask

  // A frame is legal when the xor checksum matches, opcode is 0..2 and the channel exists.
  task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output bit ok);
    int op, ch;
    op = int'(b0[3:2]);
    ch = int'(b0[1:0]);
    ok = ((b0 ^ b1) == b2) && (op != 3) && (ch < N_CH);
    if (!ok) model_reject();
    else begin
      if (op == 0) m_duty[ch] = b1;
      else if (op == 1) m_en[ch] = b1[0];
      else for (int c = 0; c < N_CH; c++) m_duty[c] = b1;
      m_bytes = {b0, b1, b2};
    end
  endtask

  task automatic check_state(input string tag);
    logic [8*N_CH-1:0] ed;
    logic [N_CH-1:0]   ee;
    for (int c = 0; c < N_CH; c++) begin
      ed[8*c +: 8] = m_duty[c];
      ee[c]        = m_en[c];
    end
    chk({tag, "_duty"},  32'(duty_o), 32'(ed));
    chk({tag, "_en"},    32'(en_o), 32'(ee));
    chk({tag, "_bytes"}, 32'(uart_rx_bytes), 32'(m_bytes));
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Called #1 after the edge that consumed byte2; checks the k+1 result.
  task automatic finish_apply(input string tag, input bit ok);
    chk({tag, "_pre_ok"}, 32'(frame_ok), 32'd0);
    chk({tag, "_apply_ready"}, 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_frame_ok"},  32'(frame_ok), 32'(ok));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(!ok));
    check_state(tag);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int maxgap);
    bit ok;
    model_frame(b0, b1, b2, ok);
    send_byte(b0, $urandom_range(0, maxgap));
    send_byte(b1, $urandom_range(0, maxgap));
    send_byte(b2, $urandom_range(0, maxgap));
    finish_apply(tag, ok);
  endtask

  initial begin
    bit          ok;
    bit          saw_err;
    logic [7:0]  b0, b1, b2, junk;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    check_state("rst");
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_ready", 32'(rx_ready), 32'd1);

    send_frame("set_duty", 8'hA1, 8'h80, 8'h21, 0);
    @(posedge clk); #1 chk("ok_one_cycle", 32'(frame_ok), 32'd0);
    send_frame("bad_chk", 8'hA0, 8'h55, 8'h00, 0);
    send_byte(8'h3C, 0);
    send_frame("resync", 8'hA4, 8'h01, 8'hA5, 0);
    send_frame("bcast", 8'hA8, 8'h33, 8'h9B, 0);
    send_frame("op11", 8'hAC, 8'h00, 8'hAC, 0);
    send_frame("ch_oob", 8'hA3, 8'h12, 8'hB1, 0);
    send_frame("ch_last", 8'hA2, 8'h77, 8'hD5, 0);

    // Timeout: 15 idle cycles are tolerated, the 16th drops the partial frame.
    send_byte(8'hA0, 0);
    repeat (15) @(posedge clk);
    #1 chk("to_early", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    model_reject();
    chk("to_fire", 32'(frame_err), 32'd1);
    chk("to_ready", 32'(rx_ready), 32'd1);
    check_state("to");
    send_frame("after_to", 8'hA0, 8'h10, 8'hB0, 0);

    // Byte on the expiry edge wins.
    model_frame(8'hA0, 8'h20, 8'h80, ok);
    send_byte(8'hA0, 0);
    repeat (15) @(posedge clk);
    send_byte(8'h20, 0);
    chk("race_no_err", 32'(frame_err), 32'd0);
    send_byte(8'h80, 0);
    finish_apply("race", ok);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk[7:4] == 4'hA) junk[7:4] = 4'h5;
        send_byte(junk, $urandom_range(0, 2));
      end
      b0 = {4'hA, 4'($urandom)};
      b1 = 8'($urandom);
      b2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (b0 ^ b1);
      send_frame("rand", b0, b1, b2, 5);
    end

    // Reset in the middle of a frame.
    send_byte(8'hA0, 0);
    send_byte(8'h10, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    model_reset();
    check_state("mid_rst");
    @(negedge clk) rst = 1'b0;
    #1 chk("mid_rst_ready", 32'(rx_ready), 32'd1);
    saw_err = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (frame_err) saw_err = 1'b1;
    end
    chk("mid_rst_no_err", 32'(saw_err), 32'd0);
    send_frame("post_rst", 8'hA1, 8'h80, 8'h21, 0);

    for (int i = 0; i < 300; i++) send_frame("sat", 8'hA0, 8'h55, 8'h00, 0);
    chk("sat_final", 32'(err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
